// File: rtl/complex_div_unit_controller.sv
// Divider-ownership controller: one FREE/RESERVED/BUSY/DONE machine plus latency counter per complex lane.
// Optional macro RSD_DIV_CTRL_PROTOCOL_CHECK_EN builds the sticky protocol-violation checker.
module complex_div_unit_controller #(
   parameter int ISSUE_WIDTH = 1,
   parameter int DIV_LATENCY = 34,
   parameter int CNT_W       = $clog2(DIV_LATENCY + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ISSUE_WIDTH-1:0] div_acquire,
   input  logic [ISSUE_WIDTH-1:0] div_reset_from_ci,
   input  logic [ISSUE_WIDTH-1:0] div_start,
   input  logic [ISSUE_WIDTH-1:0] div_flush,
   input  logic [ISSUE_WIDTH-1:0] div_release,
   output logic [ISSUE_WIDTH-1:0] div_free,
   output logic [ISSUE_WIDTH-1:0] div_busy,
   output logic [ISSUE_WIDTH-1:0] div_finished,
   output logic                   div_protocol_error
);

   typedef enum logic [1:0] {
      s_free     = 2'd0,
      s_reserved = 2'd1,
      s_busy     = 2'd2,
      s_done     = 2'd3
   } div_state_e;

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIV_LATENCY - 1);

   div_state_e       state_q [ISSUE_WIDTH];
   div_state_e       state_d [ISSUE_WIDTH];
   logic [CNT_W-1:0] cnt_q   [ISSUE_WIDTH];
   logic [CNT_W-1:0] cnt_d   [ISSUE_WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            state_q[i] <= s_free;
            cnt_q[i]   <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // Cancel from the issue stage and post-issue flush both kill the lane from any state.
   always_comb begin
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         if (div_flush[i] || div_reset_from_ci[i]) begin
            state_d[i] = s_free;
            cnt_d[i]   = '0;
         end else begin
            case (state_q[i])
               s_free: begin
                  if (div_acquire[i]) state_d[i] = s_reserved;
               end
               s_reserved: begin
                  if (div_start[i]) begin
                     state_d[i] = s_busy;
                     cnt_d[i]   = CNT_INIT;
                  end
               end
               s_busy: begin
                  if (cnt_q[i] == '0) state_d[i] = s_done;
                  else                cnt_d[i]   = cnt_q[i] - 1'b1;
               end
               s_done: begin
                  if (div_release[i]) state_d[i] = s_free;
               end
               default: begin
                  state_d[i] = s_free;
                  cnt_d[i]   = '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      div_free     = '0;
      div_busy     = '0;
      div_finished = '0;
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
         div_free[i]     = (state_q[i] == s_free);
         div_busy[i]     = (state_q[i] == s_busy);
         div_finished[i] = (state_q[i] == s_done);
      end
   end

`ifdef RSD_DIV_CTRL_PROTOCOL_CHECK_EN
   logic [ISSUE_WIDTH-1:0] viol;
   logic                   err_q;

   always_comb begin
      viol = '0;
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
         viol[i] = (div_acquire[i] && (state_q[i] != s_free))
                || (div_start[i]   && (state_q[i] != s_reserved))
                || (div_release[i] && (state_q[i] != s_done))
                || (div_acquire[i] && div_reset_from_ci[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else begin
         if (|viol) err_q <= 1'b1;
         for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            if (viol[i]) $error("div lane %0d protocol violation in state %s", i, state_q[i].name());
         end
      end
   end

   assign div_protocol_error = err_q;
`else
   assign div_protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_complex_div_unit_controller.sv
// Self-checking bench: constant vector table, directed latency/flush/reset sequences, random run vs. timestamp model.
module tb_complex_div_unit_controller;
   localparam int W   = 2;
   localparam int LAT = 34;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] div_acquire = '0, div_reset_from_ci = '0, div_start = '0, div_flush = '0, div_release = '0;
   logic [W-1:0] div_free, div_busy, div_finished;
   logic         div_protocol_error;

   complex_div_unit_controller #(.ISSUE_WIDTH(W), .DIV_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst),
      .div_acquire(div_acquire), .div_reset_from_ci(div_reset_from_ci),
      .div_start(div_start), .div_flush(div_flush), .div_release(div_release),
      .div_free(div_free), .div_busy(div_busy), .div_finished(div_finished),
      .div_protocol_error(div_protocol_error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails  = 0;

   // Model: a lane is owned or not; once started it is finished LAT edges after its start edge.
   bit m_own [W];
   bit m_st  [W];
   int m_sc  [W];
   bit m_err;
   int edge_n = 0;

   function automatic bit m_fin(int l, int now);
      return m_own[l] && m_st[l] && ((now - m_sc[l]) >= LAT);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   task automatic step(input logic [W-1:0] acq, rci, st, fl, rl, input logic r);
      int prev;
      bit fin_b, res_b;
      logic [W-1:0] ef, eb, ed;
      div_acquire = acq; div_reset_from_ci = rci; div_start = st; div_flush = fl; div_release = rl; rst = r;
      @(posedge clk);
      prev = edge_n;
      edge_n++;
      for (int l = 0; l < W; l++) begin
         fin_b = m_fin(l, prev);
         res_b = m_own[l] && !m_st[l];
         if (!r) begin
            if (acq[l] && m_own[l]) m_err = 1'b1;
            if (st[l] && !res_b)    m_err = 1'b1;
            if (rl[l] && !fin_b)    m_err = 1'b1;
            if (acq[l] && rci[l])   m_err = 1'b1;
         end
         if (r || fl[l] || rci[l]) m_own[l] = 1'b0;
         else if (!m_own[l]) begin
            if (acq[l]) begin m_own[l] = 1'b1; m_st[l] = 1'b0; end
         end else if (res_b) begin
            if (st[l]) begin m_st[l] = 1'b1; m_sc[l] = edge_n; end
         end else if (fin_b && rl[l]) m_own[l] = 1'b0;
      end
      if (r) m_err = 1'b0;
      #1;
      for (int l = 0; l < W; l++) begin
         ef[l] = !m_own[l];
         ed[l] = m_fin(l, edge_n);
         eb[l] = m_own[l] && m_st[l] && !ed[l];
      end
      chk("model_free", 32'(div_free), 32'(ef));
      chk("model_busy", 32'(div_busy), 32'(eb));
      chk("model_finished", 32'(div_finished), 32'(ed));
`ifdef RSD_DIV_CTRL_PROTOCOL_CHECK_EN
      chk("model_err", 32'(div_protocol_error), 32'(m_err));
`else
      chk("model_err", 32'(div_protocol_error), 32'd0);
`endif
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step('0, '0, '0, '0, '0, 1'b0);
   endtask

   typedef struct {
      logic [W-1:0] acq, rci, st, fl, rl;
      logic         r;
      logic [W-1:0] ef, eb, ed;
   } vec_t;

   vec_t tbl [14];

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1, "timeout");
   end

   initial begin
      //            acq    rci    st     fl     rl     rst   free   busy   fin
      tbl[0]  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00};
      tbl[1]  = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00};
      tbl[2]  = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00};
      tbl[3]  = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'b10, 2'b00};
      tbl[4]  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00};
      tbl[5]  = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00};
      tbl[6]  = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 2'b00};
      tbl[7]  = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b11, 2'b00, 2'b00};
      tbl[8]  = '{2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00};
      tbl[9]  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00};
      tbl[10] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 2'b11, 2'b00, 2'b00};
      tbl[11] = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00};
      tbl[12] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00};
      tbl[13] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 1'b0, 2'b10, 2'b01, 2'b00};

      // Reset then idle
      step('0, '0, '0, '0, '0, 1'b1);
      step('0, '0, '0, '0, '0, 1'b1);
      chk("reset_free", 32'(div_free), 32'h3);
      chk("reset_busy", 32'(div_busy), 32'h0);
      chk("reset_fin", 32'(div_finished), 32'h0);
      chk("reset_err", 32'(div_protocol_error), 32'h0);
      idle(2);
      chk("idle_free", 32'(div_free), 32'h3);

      // Vector table
      for (int v = 0; v < 14; v++) begin
         step(tbl[v].acq, tbl[v].rci, tbl[v].st, tbl[v].fl, tbl[v].rl, tbl[v].r);
         chk($sformatf("tbl%0d_free", v), 32'(div_free), 32'(tbl[v].ef));
         chk($sformatf("tbl%0d_busy", v), 32'(div_busy), 32'(tbl[v].eb));
         chk($sformatf("tbl%0d_fin", v), 32'(div_finished), 32'(tbl[v].ed));
      end

      // Normal divide on lane0: finished exactly LAT edges after the start edge
      step('0, '0, '0, '0, '0, 1'b1);
      step(2'b01, '0, '0, '0, '0, 1'b0);
      step('0, '0, 2'b01, '0, '0, 1'b0);
      chk("div_busy_first", 32'(div_busy), 32'h1);
      for (int k = 1; k < LAT; k++) begin
         step('0, '0, '0, '0, '0, 1'b0);
         chk("div_not_done_yet", 32'(div_finished), 32'h0);
      end
      step('0, '0, '0, '0, '0, 1'b0);
      chk("div_done_at_lat", 32'(div_finished), 32'h1);
      chk("div_busy_off", 32'(div_busy), 32'h0);
      idle(4);
      chk("div_done_hold", 32'(div_finished), 32'h1);
      step('0, '0, '0, '0, 2'b01, 1'b0);
      chk("release_free", 32'(div_free), 32'h3);
      chk("release_fin", 32'(div_finished), 32'h0);

      // Flush 10 cycles into BUSY: lane frees next edge and never finishes
      step(2'b01, '0, '0, '0, '0, 1'b0);
      step('0, '0, 2'b01, '0, '0, 1'b0);
      idle(10);
      step('0, '0, '0, 2'b01, '0, 1'b0);
      chk("flush_free", 32'(div_free), 32'h3);
      chk("flush_busy", 32'(div_busy), 32'h0);
      for (int k = 0; k < LAT + 4; k++) begin
         step('0, '0, '0, '0, '0, 1'b0);
         chk("flush_never_fin", 32'(div_finished), 32'h0);
      end

      // Mid-op reset with lane0 BUSY and lane1 DONE, then lane1 alone restarts
      step(2'b11, '0, '0, '0, '0, 1'b0);
      step('0, '0, 2'b10, '0, '0, 1'b0);
      idle(20);
      step('0, '0, 2'b01, '0, '0, 1'b0);
      idle(14);
      chk("midop_busy", 32'(div_busy), 32'h1);
      chk("midop_fin", 32'(div_finished), 32'h2);
      step('0, '0, '0, '0, '0, 1'b1);
      chk("midop_rst_free", 32'(div_free), 32'h3);
      chk("midop_rst_fin", 32'(div_finished), 32'h0);
      step(2'b10, '0, '0, '0, '0, 1'b0);
      step('0, '0, 2'b10, '0, '0, 1'b0);
      chk("indep_free", 32'(div_free), 32'h1);
      chk("indep_busy", 32'(div_busy), 32'h2);
      idle(LAT);
      chk("indep_fin", 32'(div_finished), 32'h2);
      chk("indep_lane0_free", 32'(div_free), 32'h1);

      // Randomized traffic against the model
      for (int k = 0; k < 2000; k++) begin
         logic [W-1:0] a, c, s, f, rl;
         for (int l = 0; l < W; l++) begin
            a[l]  = ($urandom_range(0, 99) < 30);
            c[l]  = ($urandom_range(0, 199) < 3);
            s[l]  = ($urandom_range(0, 99) < 30);
            f[l]  = ($urandom_range(0, 199) < 2);
            rl[l] = ($urandom_range(0, 99) < 20);
         end
         step(a, c, s, f, rl, ($urandom_range(0, 299) == 0));
      end
      idle(1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/complex_div_unit_controller.md
Name: complex_div_unit_controller

Overview:
- Responder side of the divider-lock protocol driven by the complex-integer issue stage.
- Keeps one divider-ownership state machine per complex issue lane:
  - grants the divider on acquire;
  - releases it on issue-stage cancel, pipeline flush or result consumption;
  - times the multi-cycle divide with a latency counter.
- Its per-lane free and finished flags feed the complex scheduler and the execute stage.
- Sits inside the mul/div unit, between the complex issue, execute and register-write stages.

Parameters:
- ISSUE_WIDTH, 1: number of complex issue lanes; each lane owns one divider.
- DIV_LATENCY, 34: cycles from start to result valid; legal range 2..255.
- CNT_W, $clog2(DIV_LATENCY+1): width of the latency counter (derived).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high (one clock, clk).
- div_acquire  in  ISSUE_WIDTH  issue stage reserves lane i's divider (issued DIV, not flushed/cleared).
- div_reset_from_ci  in  ISSUE_WIDTH  issue stage cancels a just-issued DIV on lane i (flush or clear).
- div_start  in  ISSUE_WIDTH  execute stage begins the divide on lane i.
- div_flush  in  ISSUE_WIDTH  recovery kills the DIV in flight on lane i (post-issue stages).
- div_release  in  ISSUE_WIDTH  write-back consumed lane i's result.
- div_free  out  ISSUE_WIDTH  lane i divider is unowned; scheduler may select a DIV.
- div_busy  out  ISSUE_WIDTH  lane i is computing.
- div_finished  out  ISSUE_WIDTH  lane i result is valid.
- div_protocol_error  out  1  sticky protocol-violation flag (see Optional Feature).

Behaviour:
- Per-lane state: FREE, RESERVED, BUSY, DONE, plus counter cnt[i].
- Reset:
  - all lanes FREE, cnt 0, div_protocol_error 0;
  - outputs after the reset edge: div_free all 1, div_busy and div_finished all 0.
  - rst in mid-operation overrides every input that cycle.
- Outputs are pure decodes of registered state, so they change only on clock edges and never combinationally from inputs:
  - div_free = FREE;
  - div_busy = BUSY;
  - div_finished = DONE.
- Priority per lane, highest first: rst; div_flush or div_reset_from_ci; normal transition.
- Transitions:
  - FREE: div_acquire -> RESERVED. div_reset_from_ci or div_flush stays FREE. div_start or div_release are ignored and count as a violation.
  - RESERVED: div_start -> BUSY with cnt = DIV_LATENCY-1. div_reset_from_ci or div_flush -> FREE. Otherwise hold.
  - BUSY: cnt decrements each cycle; when cnt==0 -> DONE. div_flush -> FREE with cnt cleared.
  - DONE: div_release -> FREE. div_flush -> FREE. Hold indefinitely otherwise.
- Latency:
  - div_start sampled at edge T gives div_finished high from edge T+DIV_LATENCY;
  - the earliest div_release is in that cycle;
  - the lane is FREE one edge after release.
- Acquire and reset in the same cycle is illegal from the issue stage; reset wins and the lane ends FREE.
- Re-acquire: acquire is honoured only in FREE, so a lane is reusable the cycle after div_free shows 1.
- Acquire in a non-FREE state is ignored; state is unchanged.
- Lanes are fully independent; no shared arbitration.

Optional Feature:
- Macro: RSD_DIV_CTRL_PROTOCOL_CHECK_EN.
- With the macro, div_protocol_error is set, and held until rst, on any of:
  - acquire when not FREE;
  - start when not RESERVED;
  - release when not DONE;
  - acquire and reset_from_ci in the same cycle.
- With the macro, simulation also issues $error naming the lane and state.
- Without the macro, div_protocol_error is tied 0 and no checking logic is built.
- State behaviour is identical either way.

Test Plan:
- Reset then idle:
  - stimulus: rst high 2 cycles, inputs 0;
  - response: div_free=1, div_busy=0, div_finished=0, div_protocol_error=0.
- Normal divide, DIV_LATENCY=34:
  - stimulus: acquire at T0, start at T1;
  - response: div_busy=1 from T2; div_finished=1 from T35;
  - stimulus: release at T40;
  - response: div_free=1 at T41.
- Issue-stage cancel:
  - stimulus: acquire at T0, div_reset_from_ci at T1;
  - response: FREE at T2; a later div_start is ignored and sets the error only with the macro.
- Flush mid-divide:
  - stimulus: acquire, start, div_flush 10 cycles into BUSY;
  - response: div_free=1 next edge; div_finished never asserts.
- Acquire plus reset collision:
  - stimulus: both asserted in one cycle;
  - response: lane FREE; div_protocol_error=1 with macro, 0 without.
- Mid-op rst and lane independence (ISSUE_WIDTH=2):
  - stimulus: lane0 BUSY, lane1 DONE, rst pulsed;
  - response: both FREE next edge, counters 0;
  - stimulus: afterwards start only lane1;
  - response: lane0 unaffected.
